// File: rtl/cluster_hart_scheduler.sv
// Round-robin time-slice owner of the shared memory port / MMU, with a drain cycle between owners.
// Optional performance counters are compiled in when HART_SCHED_PERF_EN is defined.
module cluster_hart_scheduler #(
  parameter  int N_HARTS   = 2,
  parameter  int QUANTUM_W = 8,
  localparam int SEL_W     = $clog2(N_HARTS + 1)
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  input  logic [QUANTUM_W-1:0] i_quantum,
  input  logic [N_HARTS-1:0]   i_switch_ok,
  input  logic [N_HARTS-1:0]   i_hart_active,
  input  logic                 i_mc_busy,
  input  logic                 i_tlb_flush,
  output logic [SEL_W-1:0]     o_hart_sel,
  output logic [N_HARTS-1:0]   o_grant,
  output logic                 o_switching,
  output logic [QUANTUM_W-1:0] o_quantum_left
`ifdef HART_SCHED_PERF_EN
  ,
  output logic [31:0]          o_switch_cnt,
  output logic [31:0]          o_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  state_t               r_state, w_state_next;
  logic [SEL_W-1:0]     r_sel, w_sel_next;
  logic [QUANTUM_W-1:0] r_qleft, w_qleft_next;

  logic                 w_freeze;
  logic [QUANTUM_W-1:0] w_reload;
  logic [N_HARTS-1:0]   w_sel_onehot;
  logic                 w_cur_active;
  logic                 w_cur_ok;
  logic                 w_expired;
  logic                 w_cand_valid;
  logic [SEL_W-1:0]     w_cand;
  int                   w_dist;
  int                   w_best;

  assign w_freeze  = i_mc_busy | i_tlb_flush;
  assign w_reload  = (i_quantum == '0) ? QUANTUM_W'(1) : i_quantum;
  assign w_expired = (r_qleft == '0);

  genvar gi;
  generate
    for (gi = 0; gi < N_HARTS; gi++) begin : g_onehot
      assign w_sel_onehot[gi] = (r_sel == SEL_W'(gi));
    end
  endgenerate

  assign w_cur_active = |(i_hart_active & w_sel_onehot);
  assign w_cur_ok     = |(i_switch_ok & w_sel_onehot);

  // Pick the active hart at the smallest nonzero round-robin distance after r_sel.
  always_comb begin
    w_cand_valid = 1'b0;
    w_cand       = r_sel;
    w_best       = N_HARTS;
    w_dist       = 0;
    for (int j = 0; j < N_HARTS; j++) begin
      w_dist = (j + N_HARTS - int'(r_sel)) % N_HARTS;
      if (i_hart_active[j] && (w_dist != 0) && (w_dist < w_best)) begin
        w_best       = w_dist;
        w_cand       = SEL_W'(j);
        w_cand_valid = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_qleft_next = r_qleft;
    case (r_state)
      ST_RUN: begin
        if (!w_freeze && !w_expired) begin
          w_qleft_next = r_qleft - QUANTUM_W'(1);
        end
        if (!w_freeze && w_cur_ok) begin
          if ((w_expired || !w_cur_active) && w_cand_valid) begin
            w_state_next = ST_DRAIN;
          end else if (w_expired) begin
            w_qleft_next = w_reload;
          end
        end
      end
      ST_DRAIN: begin
        if (!w_freeze) begin
          w_state_next = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        if (w_cand_valid) begin
          w_sel_next = w_cand;
        end
        w_qleft_next = w_reload;
        w_state_next = ST_RUN;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      r_state <= ST_RUN;
      r_sel   <= '0;
      r_qleft <= '1;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      r_qleft <= w_qleft_next;
    end
  end

  assign o_hart_sel     = r_sel;
  assign o_grant        = (r_state == ST_RUN) ? w_sel_onehot : '0;
  assign o_switching    = (r_state != ST_RUN);
  assign o_quantum_left = r_qleft;

`ifdef HART_SCHED_PERF_EN
  logic [31:0] r_switch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      r_switch_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (r_state != ST_RUN) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if ((r_state == ST_SWITCH) && w_cand_valid && (w_cand != r_sel)) begin
        r_switch_cnt <= r_switch_cnt + 32'd1;
      end
    end
  end

  assign o_switch_cnt = r_switch_cnt;
  assign o_stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_cluster_hart_scheduler.sv
// Bench for cluster_hart_scheduler: vector table through a scoreboard queue, then directed multi-cycle cases.
module tb_cluster_hart_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_x;

  logic [7:0] d2_quantum;
  logic [1:0] d2_ok, d2_act;
  logic       d2_mc, d2_tlb;
  logic [1:0] d2_sel;
  logic [1:0] d2_grant;
  logic       d2_sw;
  logic [7:0] d2_ql;

  logic [7:0] d4_quantum;
  logic [3:0] d4_ok, d4_act;
  logic       d4_mc, d4_tlb;
  logic [2:0] d4_sel;
  logic [3:0] d4_grant;
  logic       d4_sw;
  logic [7:0] d4_ql;

`ifdef HART_SCHED_PERF_EN
  logic [31:0] d2_switch_cnt, d2_stall_cnt;
  logic [31:0] d4_switch_cnt, d4_stall_cnt;
`endif

  cluster_hart_scheduler #(.N_HARTS(2), .QUANTUM_W(8)) u_dut2 (
    .CLK            (clk),
    .RST_X          (rst_x),
    .i_quantum      (d2_quantum),
    .i_switch_ok    (d2_ok),
    .i_hart_active  (d2_act),
    .i_mc_busy      (d2_mc),
    .i_tlb_flush    (d2_tlb),
    .o_hart_sel     (d2_sel),
    .o_grant        (d2_grant),
    .o_switching    (d2_sw),
    .o_quantum_left (d2_ql)
`ifdef HART_SCHED_PERF_EN
    ,
    .o_switch_cnt   (d2_switch_cnt),
    .o_stall_cnt    (d2_stall_cnt)
`endif
  );

  cluster_hart_scheduler #(.N_HARTS(4), .QUANTUM_W(8)) u_dut4 (
    .CLK            (clk),
    .RST_X          (rst_x),
    .i_quantum      (d4_quantum),
    .i_switch_ok    (d4_ok),
    .i_hart_active  (d4_act),
    .i_mc_busy      (d4_mc),
    .i_tlb_flush    (d4_tlb),
    .o_hart_sel     (d4_sel),
    .o_grant        (d4_grant),
    .o_switching    (d4_sw),
    .o_quantum_left (d4_ql)
`ifdef HART_SCHED_PERF_EN
    ,
    .o_switch_cnt   (d4_switch_cnt),
    .o_stall_cnt    (d4_stall_cnt)
`endif
  );

  typedef struct {
    logic [7:0] quantum;
    logic [1:0] ok;
    logic [1:0] act;
    logic       mc;
    logic       tlb;
    logic [1:0] e_sel;
    logic [1:0] e_grant;
    logic       e_sw;
    logic [7:0] e_q;
  } vec_t;

  typedef struct {
    logic [1:0] sel;
    logic [1:0] grant;
    logic       sw;
    logic [7:0] q;
    int         idx;
  } exp_t;

  vec_t vt[40];
  int   nv;
  exp_t sb[$];

  int n_checks;
  int n_pass;

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got === exp_v) n_pass++;
    else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [7:0] quantum, input logic [1:0] ok, input logic [1:0] act,
                     input logic mc, input logic tlb, input logic [1:0] e_sel,
                     input logic [1:0] e_grant, input logic e_sw, input logic [7:0] e_q);
    vt[nv].quantum = quantum;
    vt[nv].ok      = ok;
    vt[nv].act     = act;
    vt[nv].mc      = mc;
    vt[nv].tlb     = tlb;
    vt[nv].e_sel   = e_sel;
    vt[nv].e_grant = e_grant;
    vt[nv].e_sw    = e_sw;
    vt[nv].e_q     = e_q;
    nv++;
  endtask

  exp_t e;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    nv       = 0;

    //   quantum ok     act    mc tlb  sel grant  sw q
    add(8'd4, 2'b11, 2'b10, 0, 0, 2'd0, 2'b00, 1, 8'd254); // hart 0 drops -> DRAIN
    add(8'd4, 2'b11, 2'b11, 0, 0, 2'd0, 2'b00, 1, 8'd254); // SWITCH
    add(8'd4, 2'b11, 2'b11, 0, 0, 2'd1, 2'b10, 0, 8'd4);
    add(8'd4, 2'b11, 2'b11, 0, 0, 2'd1, 2'b10, 0, 8'd3);
    add(8'd4, 2'b11, 2'b11, 0, 0, 2'd1, 2'b10, 0, 8'd2);
    add(8'd4, 2'b11, 2'b11, 0, 0, 2'd1, 2'b10, 0, 8'd1);
    add(8'd4, 2'b11, 2'b11, 0, 0, 2'd1, 2'b10, 0, 8'd0);
    add(8'd4, 2'b11, 2'b11, 0, 0, 2'd1, 2'b00, 1, 8'd0);   // expiry -> DRAIN
    add(8'd4, 2'b11, 2'b11, 1, 0, 2'd1, 2'b00, 1, 8'd0);   // frozen in DRAIN
    add(8'd4, 2'b11, 2'b11, 0, 0, 2'd1, 2'b00, 1, 8'd0);   // SWITCH
    add(8'd4, 2'b11, 2'b01, 0, 0, 2'd0, 2'b01, 0, 8'd4);   // wrap to hart 0
    add(8'd4, 2'b11, 2'b01, 0, 0, 2'd0, 2'b01, 0, 8'd3);
    add(8'd4, 2'b11, 2'b01, 0, 0, 2'd0, 2'b01, 0, 8'd2);
    add(8'd4, 2'b11, 2'b01, 0, 0, 2'd0, 2'b01, 0, 8'd1);
    add(8'd4, 2'b11, 2'b01, 0, 0, 2'd0, 2'b01, 0, 8'd0);
    add(8'd4, 2'b11, 2'b01, 0, 0, 2'd0, 2'b01, 0, 8'd4);   // no candidate: reload
    add(8'd0, 2'b11, 2'b01, 0, 0, 2'd0, 2'b01, 0, 8'd3);
    add(8'd0, 2'b11, 2'b01, 0, 0, 2'd0, 2'b01, 0, 8'd2);
    add(8'd0, 2'b11, 2'b01, 0, 0, 2'd0, 2'b01, 0, 8'd1);
    add(8'd0, 2'b11, 2'b01, 0, 0, 2'd0, 2'b01, 0, 8'd0);
    add(8'd0, 2'b11, 2'b01, 0, 0, 2'd0, 2'b01, 0, 8'd1);   // quantum 0 reloads as 1
    add(8'd0, 2'b11, 2'b01, 0, 0, 2'd0, 2'b01, 0, 8'd0);
    add(8'd0, 2'b11, 2'b01, 0, 0, 2'd0, 2'b01, 0, 8'd1);
    add(8'd0, 2'b11, 2'b01, 0, 1, 2'd0, 2'b01, 0, 8'd1);   // tlb flush holds count
    add(8'd0, 2'b11, 2'b01, 0, 0, 2'd0, 2'b01, 0, 8'd0);
    add(8'd0, 2'b10, 2'b11, 0, 0, 2'd0, 2'b01, 0, 8'd0);   // own switch_ok low
    add(8'd0, 2'b01, 2'b11, 0, 0, 2'd0, 2'b00, 1, 8'd0);   // DRAIN
    add(8'd0, 2'b01, 2'b11, 0, 0, 2'd0, 2'b00, 1, 8'd0);   // SWITCH
    add(8'd0, 2'b01, 2'b01, 0, 0, 2'd0, 2'b01, 0, 8'd1);   // candidate gone at SWITCH
    add(8'd7, 2'b11, 2'b01, 0, 0, 2'd0, 2'b01, 0, 8'd0);
    add(8'd7, 2'b11, 2'b01, 0, 0, 2'd0, 2'b01, 0, 8'd7);   // new quantum at reload

    rst_x      = 1'b0;
    d2_quantum = 8'd4;  d2_ok = 2'b11;   d2_act = 2'b11;   d2_mc = 1'b0; d2_tlb = 1'b0;
    d4_quantum = 8'd2;  d4_ok = 4'b1111; d4_act = 4'b1111; d4_mc = 1'b0; d4_tlb = 1'b0;
    tick();
    tick();
    chk("rst_sel",   0, 32'(d2_sel),   32'd0);
    chk("rst_grant", 0, 32'(d2_grant), 32'd1);
    chk("rst_sw",    0, 32'(d2_sw),    32'd0);
    chk("rst_q",     0, 32'(d2_ql),    32'd255);
    rst_x = 1'b1;

    for (int i = 0; i < nv; i++) begin
      d2_quantum = vt[i].quantum;
      d2_ok      = vt[i].ok;
      d2_act     = vt[i].act;
      d2_mc      = vt[i].mc;
      d2_tlb     = vt[i].tlb;
      sb.push_back('{vt[i].e_sel, vt[i].e_grant, vt[i].e_sw, vt[i].e_q, i});
      tick();
      e = sb.pop_front();
      chk("vec_sel",   e.idx, 32'(d2_sel),   32'(e.sel));
      chk("vec_grant", e.idx, 32'(d2_grant), 32'(e.grant));
      chk("vec_sw",    e.idx, 32'(d2_sw),    32'(e.sw));
      chk("vec_q",     e.idx, 32'(d2_ql),    32'(e.q));
      $display("vec %0d: sel=%0d grant=%b sw=%b q=%0d", e.idx, d2_sel, d2_grant, d2_sw, d2_ql);
    end

    // Inactive hart with 200 cycles left gives up the port immediately.
    rst_x = 1'b0; d2_quantum = 8'd200; d2_ok = 2'b11; d2_act = 2'b11; d2_mc = 1'b0; d2_tlb = 1'b0;
    tick();
    rst_x = 1'b1;
    d2_act = 2'b10; tick(); d2_act = 2'b11; tick(); tick();
    chk("b_setup_sel", 0, 32'(d2_sel), 32'd1);
    d2_act = 2'b01; tick(); d2_act = 2'b11; tick(); tick();
    chk("b_setup_sel", 1, 32'(d2_sel), 32'd0);
    chk("b_setup_q",   1, 32'(d2_ql),  32'd200);
    d2_act = 2'b10; tick();
    chk("b_drain_sw",    0, 32'(d2_sw),    32'd1);
    chk("b_drain_grant", 0, 32'(d2_grant), 32'd0);
    d2_act = 2'b11; tick();
    chk("b_switch_sw",  0, 32'(d2_sw),  32'd1);
    chk("b_switch_sel", 0, 32'(d2_sel), 32'd0);
    tick();
    chk("b_new_sel",   0, 32'(d2_sel),   32'd1);
    chk("b_new_grant", 0, 32'(d2_grant), 32'd2);
    chk("b_new_sw",    0, 32'(d2_sw),    32'd0);
    $display("seq B: sel=%0d grant=%b q=%0d", d2_sel, d2_grant, d2_ql);

    // Memory controller busy holds DRAIN for 10 cycles.
    d2_quantum = 8'd2; d2_act = 2'b01; tick();
    chk("c_drain_sw", 0, 32'(d2_sw), 32'd1);
    d2_mc = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("c_hold_sw",    k, 32'(d2_sw),    32'd1);
      chk("c_hold_grant", k, 32'(d2_grant), 32'd0);
      chk("c_hold_q",     k, 32'(d2_ql),    32'd199);
    end
    d2_mc = 1'b0; tick();
    chk("c_switch_sw",  0, 32'(d2_sw),  32'd1);
    chk("c_switch_sel", 0, 32'(d2_sel), 32'd1);
    tick();
    chk("c_new_sel",   0, 32'(d2_sel),   32'd0);
    chk("c_new_grant", 0, 32'(d2_grant), 32'd1);
    chk("c_new_sw",    0, 32'(d2_sw),    32'd0);
    chk("c_new_q",     0, 32'(d2_ql),    32'd2);
    $display("seq C: sel=%0d grant=%b q=%0d", d2_sel, d2_grant, d2_ql);

    // Reset during SWITCH aborts the hand-over.
    d2_act = 2'b10; tick();
    chk("e_drain_sw", 0, 32'(d2_sw), 32'd1);
    tick();
    chk("e_switch_sw", 0, 32'(d2_sw), 32'd1);
    rst_x = 1'b0; tick();
    chk("e_rst_sel",   0, 32'(d2_sel),   32'd0);
    chk("e_rst_grant", 0, 32'(d2_grant), 32'd1);
    chk("e_rst_sw",    0, 32'(d2_sw),    32'd0);
    chk("e_rst_q",     0, 32'(d2_ql),    32'd255);
`ifdef HART_SCHED_PERF_EN
    chk("e_rst_switch_cnt", 0, d2_switch_cnt, 32'd0);
    chk("e_rst_stall_cnt",  0, d2_stall_cnt,  32'd0);
`endif
    $display("seq E: sel=%0d grant=%b sw=%b q=%0d", d2_sel, d2_grant, d2_sw, d2_ql);

    // Four harts: wrap from 3 to 0, then candidate recomputed at SWITCH.
    d4_quantum = 8'd2; d4_ok = 4'b1111; d4_act = 4'b1111; d4_mc = 1'b0; d4_tlb = 1'b0;
    tick();
    rst_x = 1'b1;
    chk("d_rst_sel",   0, 32'(d4_sel),   32'd0);
    chk("d_rst_grant", 0, 32'(d4_grant), 32'd1);
    d4_act = 4'b1000; tick();
    chk("d_drain_sw", 0, 32'(d4_sw), 32'd1);
    d4_act = 4'b1001; tick(); tick();
    chk("d_sel3",       0, 32'(d4_sel),   32'd3);
    chk("d_sel3_grant", 0, 32'(d4_grant), 32'd8);
    chk("d_sel3_q",     0, 32'(d4_ql),    32'd2);
    tick(); tick();
    chk("d_expired_q", 0, 32'(d4_ql), 32'd0);
    tick();
    chk("d_drain_sw",    1, 32'(d4_sw),    32'd1);
    chk("d_drain_grant", 1, 32'(d4_grant), 32'd0);
    tick(); tick();
    chk("d_wrap_sel",   0, 32'(d4_sel),   32'd0);
    chk("d_wrap_grant", 0, 32'(d4_grant), 32'd1);
    chk("d_wrap_sw",    0, 32'(d4_sw),    32'd0);
    chk("d_wrap_q",     0, 32'(d4_ql),    32'd2);
    tick(); tick(); tick();
    chk("d_drain_sw", 2, 32'(d4_sw), 32'd1);
    d4_act = 4'b0100; tick(); tick();
    chk("d_recomp_sel",   0, 32'(d4_sel),   32'd2);
    chk("d_recomp_grant", 0, 32'(d4_grant), 32'd4);
    chk("d_recomp_sw",    0, 32'(d4_sw),    32'd0);
    $display("seq D: sel=%0d grant=%b q=%0d", d4_sel, d4_grant, d4_ql);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
